// File: rtl/ring_pos_monitor_if.sv
// rtl/ring_pos_monitor_if.sv - ring bus and monitor result signals
// Ports (grouped):
//   i_step     advance strobe shared with the ring shifter
//   i_ring     registered ring shifter output
//   i_clr_err  clear fault and resync
//   o_pos, o_pos_valid, o_lap_cnt, o_lap_tick, o_err, o_err_code  monitor results
// Modports: master drives the ring side, slave is the monitor.
interface ring_pos_monitor_if #(
    parameter int WIDTH = 4,
    parameter int LAP_W = 8
);
    localparam int POS_W = $clog2(WIDTH);

    logic             i_step;
    logic [WIDTH-1:0] i_ring;
    logic             i_clr_err;
    logic [POS_W-1:0] o_pos;
    logic             o_pos_valid;
    logic [LAP_W-1:0] o_lap_cnt;
    logic             o_lap_tick;
    logic             o_err;
    logic [1:0]       o_err_code;

    modport master (
        output i_step, i_ring, i_clr_err,
        input  o_pos, o_pos_valid, o_lap_cnt, o_lap_tick, o_err, o_err_code
    );

    modport slave (
        input  i_step, i_ring, i_clr_err,
        output o_pos, o_pos_valid, o_lap_cnt, o_lap_tick, o_err, o_err_code
    );
endinterface

// File: rtl/ring_pos_monitor.sv
// rtl/ring_pos_monitor.sv - one-hot ring position decoder, lap counter and fault checker
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  ring_pos_monitor_if.slave: step/ring/clear in, position/lap/fault out
// All outputs are registered.
module ring_pos_monitor #(
    parameter int WIDTH = 4,
    parameter int LAP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ring_pos_monitor_if.slave    bus
);
    localparam int POS_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    state_t           state_q, state_d;
    logic             step_d_q;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             valid_q, valid_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic             ring_one_hot;
    logic [POS_W-1:0] ring_idx;
    logic [WIDTH-1:0] ref_rot;
    logic [1:0]       cause;

    always_comb begin
        ring_one_hot = (bus.i_ring != '0) && ((bus.i_ring & (bus.i_ring - ONE)) == '0);
        ring_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.i_ring[i]) begin
                ring_idx = POS_W'(i);
            end
        end
        // What the shifter must present one cycle after a step.
        ref_rot = {ref_q[0], ref_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        lap_d   = lap_q;
        tick_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        cause   = 2'b00;

        if (bus.i_clr_err) begin
            // Clear wins over anything detected this cycle; the sample is dropped.
            state_d = SYNC;
            err_d   = 1'b0;
            code_d  = 2'b00;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (ring_one_hot) begin
                        ref_d   = bus.i_ring;
                        pos_d   = ring_idx;
                        valid_d = 1'b1;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!ring_one_hot) begin
                        cause = 2'b01;
                    end else if (step_d_q) begin
                        if (bus.i_ring == ref_rot) begin
                            ref_d = bus.i_ring;
                            // Power-of-two width: plain subtraction wraps mod WIDTH.
                            pos_d = pos_q - POS_W'(1);
                            if (pos_q == POS_W'(1)) begin
                                lap_d  = lap_q + LAP_W'(1);
                                tick_d = 1'b1;
                            end
                        end else begin
                            cause = 2'b10;
                        end
                    end else if (bus.i_ring != ref_q) begin
                        cause = 2'b11;
                    end
                    if (cause != 2'b00) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                        code_d  = cause;
                        valid_d = 1'b0;
                    end
                end
                FAULT: begin
                    // Sticky: first cause is kept until clear or reset.
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SYNC;
            step_d_q <= 1'b0;
            ref_q    <= '0;
            pos_q    <= '0;
            valid_q  <= 1'b0;
            lap_q    <= '0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            step_d_q <= bus.i_step;
            ref_q    <= ref_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            lap_q    <= lap_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign bus.o_pos       = pos_q;
    assign bus.o_pos_valid = valid_q;
    assign bus.o_lap_cnt   = lap_q;
    assign bus.o_lap_tick  = tick_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_code  = code_q;
endmodule
